// File: rtl/mode_pkg.sv
// Types and constants shared by mode_select and the mode/status report transmitter.
package mode_pkg;

    typedef enum logic [1:0] {
        Initialise = 2'b00,
        Manual     = 2'b01,
        Auto       = 2'b10
    } mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_t;

    localparam logic [7:0] REPORT_HEADER = 8'hA5;
    localparam int         REPORT_LEN    = 3;

    function automatic logic [7:0] report_checksum(input logic [7:0] header,
                                                   input logic [7:0] status);
        return header ^ status;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser: start, 8 data bits LSB first, optional even parity
// (MODE_REPORT_PARITY_EN), stop. A load during the last stop cycle chains the next byte with no gap.
module uart_tx_byte
    import mode_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle,
    output logic       byte_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             last_tick;

    assign last_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign tx        = tx_q;
    assign idle      = (state_q == IDLE);
    assign byte_end  = (state_q == STOP) && last_tick;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (load) begin
                    state_d   = START;
                    data_d    = data;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (last_tick) begin
                    cnt_d     = '0;
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = data_q[0];
                end
            end
            DATA: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef MODE_REPORT_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = data_q[bit_idx_d];
                    end
                end
            end
`ifdef MODE_REPORT_PARITY_EN
            PARITY: begin
                if (last_tick) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (last_tick) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    if (load) begin
                        state_d = START;
                        data_d  = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/mode_report_tx.sv
// Sends 3-byte mode/status reports (header, status, checksum) back to the Arduino.
// Define MODE_REPORT_PARITY_EN for 8E1 framing instead of 8N1.
module mode_report_tx
    import mode_pkg::*;
#(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 115200,
    parameter logic [7:0] HEADER   = REPORT_HEADER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       manual_on,
    input  logic       auto_on,
    input  logic       send_req,
    input  logic [5:0] user_status,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [1:0] LAST_BYTE    = 2'(REPORT_LEN - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("mode_report_tx: CLK_FREQ/BAUD must be at least 2");
    end

    logic [1:0] prev_mode_q, prev_mode_d;
    logic [7:0] status_q, status_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pending_q, pending_d;

    logic [1:0] mode_now;
    logic       trigger;
    logic       load;
    logic [7:0] load_data;
    logic       tx_idle;
    logic       byte_end;

    assign mode_now = {auto_on, manual_on};
    assign trigger  = (mode_now != prev_mode_q) || send_req;
    assign busy     = busy_q;
    assign done     = done_q;

    // Byte sequencing: start on trigger/pending, chain the next byte on each stop-bit end.
    always_comb begin
        prev_mode_d = mode_now;
        status_d    = status_q;
        byte_idx_d  = byte_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pending_d   = pending_q;
        load        = 1'b0;
        load_data   = HEADER;
        if (!busy_q) begin
            if ((trigger || pending_q) && tx_idle) begin
                load       = 1'b1;
                busy_d     = 1'b1;
                pending_d  = 1'b0;
                status_d   = {auto_on, manual_on, user_status};
                byte_idx_d = '0;
            end
        end else begin
            if (trigger) begin
                pending_d = 1'b1;
            end
            if (byte_end) begin
                if (byte_idx_q < LAST_BYTE) begin
                    load       = 1'b1;
                    load_data  = (byte_idx_q == 2'd0) ? status_q
                                                      : report_checksum(HEADER, status_q);
                    byte_idx_d = byte_idx_q + 2'd1;
                end else begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    byte_idx_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_mode_q <= 2'b00;
            status_q    <= '0;
            byte_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            prev_mode_q <= prev_mode_d;
            status_q    <= status_d;
            byte_idx_q  <= byte_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pending_q   <= pending_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data    (load_data),
        .tx      (tx),
        .idle    (tx_idle),
        .byte_end(byte_end)
    );

endmodule
